// File: rtl/lt_uint_serial_ctrl_if.sv
// Operand/result handshake bundle for the serial unsigned less-than controller.
// The master side supplies operands and consumes the result; the slave is the controller.
interface lt_uint_serial_ctrl_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             y;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y
  );
endinterface

// File: rtl/lt_uint_serial_ctrl.sv
// Chunk-serial unsigned A < B: one CHUNK-bit borrow slice reused LSB chunk first.
// Operands arrive and the result leaves over valid/ready handshakes.
module lt_uint_serial_ctrl #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned CHUNK     = 8,
  parameter int unsigned IMPL_TYPE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lt_uint_serial_ctrl_if.slave  bus,
  output logic                  busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
    $error("lt_uint_serial_ctrl: WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [CntW-1:0]   cnt_q;
  logic              borrow_q;
  logic              y_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic              b_out;

  // Operand registers shift right each RUN cycle, so the live chunk is always at the bottom.
  assign a_chunk = a_q[CHUNK-1:0];
  assign b_chunk = b_q[CHUNK-1:0];

  if (IMPL_TYPE == 0) begin : g_slice_arith
    // a - b - borrow underflows exactly when a < b + borrow.
    assign b_out = ({1'b0, a_chunk} < ({1'b0, b_chunk} + {{CHUNK{1'b0}}, borrow_q}));
  end else begin : g_slice_ripple
    always_comb begin
      logic bw;
      bw = borrow_q;
      for (int i = 0; i < int'(CHUNK); i++) begin
        bw = (~a_chunk[i] & b_chunk[i]) | (~(a_chunk[i] ^ b_chunk[i]) & bw);
      end
      b_out = bw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      y_q         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            b_q        <= bus.b;
            cnt_q      <= '0;
            borrow_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          borrow_q <= b_out;
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          if (cnt_q == CntW'(NCHUNK - 1)) begin
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          // First DONE cycle publishes the final borrow; the result then holds until taken.
          if (!out_valid_q) begin
            y_q         <= borrow_q;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;
  assign busy          = busy_q;

endmodule
